// File: rtl/eth_tx_frame_length_monitor.sv
// rtl/eth_tx_frame_length_monitor.sv - passive TX stream frame length/status monitor with descriptor FIFO (optional counters: ETH_TX_LEN_MON_COUNTERS_EN)
module eth_tx_frame_length_monitor #(
    parameter int DATA_WIDTH   = 8,
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int LENGTH_WIDTH = 16,
    parameter int MIN_LENGTH   = 64,
    parameter int MAX_LENGTH   = 1522,
    parameter int DEPTH        = 16,
    parameter int DROP_BAD     = 0
) (
    input  logic                     tx_clk,
    input  logic                     tx_rst,
    input  logic [KEEP_WIDTH-1:0]    mon_tkeep,
    input  logic                     mon_tvalid,
    input  logic                     mon_tready,
    input  logic                     mon_tlast,
    input  logic                     mon_tuser,
    output logic [LENGTH_WIDTH-1:0]  len_tdata,
    output logic [2:0]               len_tstatus,
    output logic                     len_tvalid,
    input  logic                     len_tready,
    output logic [$clog2(DEPTH):0]   len_count,
    output logic                     frame_active,
    output logic                     overflow
`ifdef ETH_TX_LEN_MON_COUNTERS_EN
    ,
    output logic [31:0]              frame_count,
    output logic [31:0]              byte_count,
    output logic [31:0]              drop_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int N_W   = $clog2(KEEP_WIDTH + 1);
    localparam int SUM_W = LENGTH_WIDTH + N_W;
    localparam int CMP_W = LENGTH_WIDTH + 32;
    localparam int ENT_W = LENGTH_WIDTH + 3;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [LENGTH_WIDTH-1:0] r_acc;
    logic [N_W-1:0]          w_n;
    logic [SUM_W-1:0]        w_sum;
    logic [LENGTH_WIDTH-1:0] w_final;
    logic                    w_beat;
    logic                    w_last;
    logic                    w_runt;
    logic                    w_over;
    logic [2:0]              w_status;
    logic                    w_push_req;
    logic                    w_push_ok;
    logic                    w_pop;
    logic                    w_drop;
    logic [ENT_W-1:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_count;
    logic                    r_overflow;
    logic [ENT_W-1:0]        w_head;

    assign w_beat = mon_tvalid && mon_tready;
    assign w_last = w_beat && mon_tlast;

    generate
        if (KEEP_WIDTH == 1) begin : g_single
            logic w_unused_keep;
            assign w_unused_keep = mon_tkeep[0];
            assign w_n           = N_W'(1);
        end else begin : g_multi
            always_comb begin
                w_n = '0;
                for (int i = 0; i < KEEP_WIDTH; i++) begin
                    w_n = w_n + N_W'(mon_tkeep[i]);
                end
            end
        end
    endgenerate

    // Sum is wide enough that any carry past LENGTH_WIDTH means saturation.
    assign w_sum   = SUM_W'(r_acc) + SUM_W'(w_n);
    assign w_final = (|w_sum[SUM_W-1:LENGTH_WIDTH]) ? '1 : w_sum[LENGTH_WIDTH-1:0];

    assign w_runt   = CMP_W'(w_final) < CMP_W'(MIN_LENGTH);
    assign w_over   = CMP_W'(w_final) > CMP_W'(MAX_LENGTH);
    assign w_status = {mon_tuser, w_over, w_runt};

    assign len_tvalid = (r_count != '0);
    assign w_pop      = len_tvalid && len_tready;
    assign w_push_req = w_last && !((DROP_BAD != 0) && mon_tuser);
    // A pop in the same cycle frees a slot, so a full FIFO can still take the push.
    assign w_push_ok  = w_push_req && ((r_count < CNT_W'(DEPTH)) || w_pop);
    assign w_drop     = w_push_req && !w_push_ok;

    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        frame_active = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_beat && !mon_tlast) begin
                    w_next = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                frame_active = 1'b1;
                if (w_last) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            r_acc <= '0;
        end else if (w_beat) begin
            r_acc <= mon_tlast ? '0 : w_final;
        end
    end

    always_ff @(posedge tx_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= {w_final, w_status};
        end
    end

    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_drop;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head is masked while empty so the outputs read zero rather than stale RAM.
    assign w_head      = r_mem[r_rd_ptr];
    assign len_tdata   = len_tvalid ? w_head[ENT_W-1:3] : '0;
    assign len_tstatus = len_tvalid ? w_head[2:0] : 3'b000;
    assign len_count   = r_count;
    assign overflow    = r_overflow;

`ifdef ETH_TX_LEN_MON_COUNTERS_EN
    logic [31:0] r_frame_count;
    logic [31:0] r_byte_count;
    logic [31:0] r_drop_count;

    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            r_frame_count <= '0;
            r_byte_count  <= '0;
            r_drop_count  <= '0;
        end else begin
            if (w_last) begin
                r_frame_count <= r_frame_count + 32'd1;
            end
            if (w_beat) begin
                r_byte_count <= r_byte_count + 32'(w_n);
            end
            if (w_drop || (w_last && (DROP_BAD != 0) && mon_tuser)) begin
                r_drop_count <= r_drop_count + 32'd1;
            end
        end
    end

    assign frame_count = r_frame_count;
    assign byte_count  = r_byte_count;
    assign drop_count  = r_drop_count;
`endif

endmodule

// File: tb/tb_eth_tx_frame_length_monitor.sv
// tb/tb_eth_tx_frame_length_monitor.sv - self-checking bench for eth_tx_frame_length_monitor
module tb_eth_tx_frame_length_monitor;

    typedef struct packed {
        logic [1:0]  idx;
        logic [15:0] len;
        logic [2:0]  st;
    } exp_t;

    logic        tx_clk = 1'b0;
    logic        tx_rst;
    logic [3:0]  s_valid;
    logic        s_ready;
    logic [3:0]  s_keep32;
    logic        s_keep8;
    logic        s_last;
    logic        s_user;
    logic [3:0]  rdy;

    logic [3:0]  o_vld;
    logic [3:0]  o_act;
    logic [3:0]  o_ovf;
    logic [15:0] d0, d1, d3;
    logic [7:0]  d2;
    logic [2:0]  st0, st1, st2, st3;
    logic [4:0]  c0, c2, c3;
    logic [2:0]  c1;
    logic [15:0] o_data [4];
    logic [2:0]  o_stat [4];
    logic [4:0]  o_cnt  [4];
`ifdef ETH_TX_LEN_MON_COUNTERS_EN
    logic [31:0] fc [4];
    logic [31:0] bc [4];
    logic [31:0] dc [4];
`endif

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ovf_cnt [4];

    always #5 tx_clk = ~tx_clk;

    eth_tx_frame_length_monitor #(.DATA_WIDTH(32)) u0 (
        .tx_clk(tx_clk), .tx_rst(tx_rst), .mon_tkeep(s_keep32), .mon_tvalid(s_valid[0]),
        .mon_tready(s_ready), .mon_tlast(s_last), .mon_tuser(s_user), .len_tdata(d0),
        .len_tstatus(st0), .len_tvalid(o_vld[0]), .len_tready(rdy[0]), .len_count(c0),
        .frame_active(o_act[0]), .overflow(o_ovf[0])
`ifdef ETH_TX_LEN_MON_COUNTERS_EN
        , .frame_count(fc[0]), .byte_count(bc[0]), .drop_count(dc[0])
`endif
    );

    eth_tx_frame_length_monitor #(.DATA_WIDTH(8), .DEPTH(4)) u1 (
        .tx_clk(tx_clk), .tx_rst(tx_rst), .mon_tkeep(s_keep8), .mon_tvalid(s_valid[1]),
        .mon_tready(s_ready), .mon_tlast(s_last), .mon_tuser(s_user), .len_tdata(d1),
        .len_tstatus(st1), .len_tvalid(o_vld[1]), .len_tready(rdy[1]), .len_count(c1),
        .frame_active(o_act[1]), .overflow(o_ovf[1])
`ifdef ETH_TX_LEN_MON_COUNTERS_EN
        , .frame_count(fc[1]), .byte_count(bc[1]), .drop_count(dc[1])
`endif
    );

    eth_tx_frame_length_monitor #(.DATA_WIDTH(8), .LENGTH_WIDTH(8)) u2 (
        .tx_clk(tx_clk), .tx_rst(tx_rst), .mon_tkeep(s_keep8), .mon_tvalid(s_valid[2]),
        .mon_tready(s_ready), .mon_tlast(s_last), .mon_tuser(s_user), .len_tdata(d2),
        .len_tstatus(st2), .len_tvalid(o_vld[2]), .len_tready(rdy[2]), .len_count(c2),
        .frame_active(o_act[2]), .overflow(o_ovf[2])
`ifdef ETH_TX_LEN_MON_COUNTERS_EN
        , .frame_count(fc[2]), .byte_count(bc[2]), .drop_count(dc[2])
`endif
    );

    eth_tx_frame_length_monitor #(.DATA_WIDTH(8), .DROP_BAD(1)) u3 (
        .tx_clk(tx_clk), .tx_rst(tx_rst), .mon_tkeep(s_keep8), .mon_tvalid(s_valid[3]),
        .mon_tready(s_ready), .mon_tlast(s_last), .mon_tuser(s_user), .len_tdata(d3),
        .len_tstatus(st3), .len_tvalid(o_vld[3]), .len_tready(rdy[3]), .len_count(c3),
        .frame_active(o_act[3]), .overflow(o_ovf[3])
`ifdef ETH_TX_LEN_MON_COUNTERS_EN
        , .frame_count(fc[3]), .byte_count(bc[3]), .drop_count(dc[3])
`endif
    );

    always_comb begin
        o_data[0] = d0;  o_data[1] = d1;  o_data[2] = {8'h00, d2};  o_data[3] = d3;
        o_stat[0] = st0; o_stat[1] = st1; o_stat[2] = st2;          o_stat[3] = st3;
        o_cnt[0]  = c0;  o_cnt[1]  = {2'b00, c1}; o_cnt[2] = c2;    o_cnt[3]  = c3;
    end

    // Scoreboard: every accepted descriptor must match the oldest expected entry.
    always @(negedge tx_clk) begin
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (o_ovf[i]) ovf_cnt[i]++;
            if (o_vld[i] && rdy[i] && !tx_rst) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra inst %0d: got len %0d status %b, required no descriptor",
                             i, o_data[i], o_stat[i]);
                end else begin
                    e = exp_q.pop_front();
                    if (e.idx !== 2'(i) || o_data[i] !== e.len || o_stat[i] !== e.st) begin
                        errors++;
                        $display("FAIL sb_desc inst %0d: got len %0d status %b, required inst %0d len %0d status %b",
                                 i, o_data[i], o_stat[i], e.idx, e.len, e.st);
                    end
                end
            end
        end
    end

    task automatic beat(input int idx, input logic [3:0] keep, input logic last, input logic user);
        s_valid[idx] = 1'b1;
        s_keep32     = keep;
        s_keep8      = keep[0];
        s_last       = last;
        s_user       = user;
        @(posedge tx_clk);
        #1;
        s_valid  = '0;
        s_keep32 = '0;
        s_keep8  = 1'b0;
        s_last   = 1'b0;
        s_user   = 1'b0;
    endtask

    task automatic frame8(input int idx, input int len, input logic user);
        for (int j = 0; j < len; j++) begin
            beat(idx, 4'h1, j == len - 1, user && (j == len - 1));
        end
    endtask

    task automatic push_exp(input int idx, input int len, input logic [2:0] st);
        exp_t e;
        e.idx = 2'(idx);
        e.len = 16'(len);
        e.st  = st;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(output int left);
        for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(posedge tx_clk);
        repeat (2) @(posedge tx_clk);
        #1;
        left = exp_q.size();
    endtask

    task automatic test_reset;
        #2;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({o_vld[i], o_data[i], o_stat[i], o_cnt[i], o_act[i], o_ovf[i]} !== 27'd0) begin
                errors++;
                $display("FAIL reset_outputs inst %0d: got vld %b data %0d st %b cnt %0d act %b ovf %b, required all 0",
                         i, o_vld[i], o_data[i], o_stat[i], o_cnt[i], o_act[i], o_ovf[i]);
            end
        end
`ifdef ETH_TX_LEN_MON_COUNTERS_EN
        checks++;
        if ({fc[3], bc[3], dc[3]} !== 96'd0) begin
            errors++;
            $display("FAIL reset_counters: got %0d/%0d/%0d, required 0/0/0", fc[3], bc[3], dc[3]);
        end
`endif
        @(posedge tx_clk);
        #1;
        tx_rst = 1'b0;
        repeat (2) @(posedge tx_clk);
        #1;
    endtask

    task automatic test_runt_wide;
        int left;
        push_exp(0, 62, 3'b001);
        beat(0, 4'hF, 1'b0, 1'b0);
        checks++;
        if (o_act[0] !== 1'b1) begin
            errors++;
            $display("FAIL active_mid_frame: got %b, required 1", o_act[0]);
        end
        for (int j = 0; j < 14; j++) beat(0, 4'hF, 1'b0, 1'b0);
        beat(0, 4'h3, 1'b1, 1'b0);
        checks++;
        if (o_vld[0] !== 1'b1 || o_data[0] !== 16'd62 || o_act[0] !== 1'b0) begin
            errors++;
            $display("FAIL latency_62: got vld %b len %0d act %b, required vld 1 len 62 act 0",
                     o_vld[0], o_data[0], o_act[0]);
        end
        // tkeep=0 beat and a valid-without-ready beat contribute nothing
        push_exp(0, 5, 3'b001);
        beat(0, 4'hF, 1'b0, 1'b0);
        s_valid[0] = 1'b1;
        s_keep32   = 4'hF;
        s_ready    = 1'b0;
        @(posedge tx_clk);
        #1;
        s_valid  = '0;
        s_keep32 = '0;
        s_ready  = 1'b1;
        beat(0, 4'h0, 1'b0, 1'b0);
        beat(0, 4'h1, 1'b1, 1'b0);
        wait_drain(left);
        checks++;
        if (left !== 0) begin
            errors++;
            $display("FAIL drain_wide: got %0d pending, required 0", left);
        end
    endtask

    task automatic test_oversize_bad;
        int left;
        int          lens [5] = '{1523, 64, 1522, 63, 64};
        logic        usr  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [2:0]  sts  [5] = '{3'b010, 3'b100, 3'b000, 3'b001, 3'b000};
        ovf_cnt[1] = 0;
        for (int f = 0; f < 5; f++) begin
            push_exp(1, lens[f], sts[f]);
            frame8(1, lens[f], usr[f]);
        end
        wait_drain(left);
        checks++;
        if (left !== 0 || ovf_cnt[1] !== 0) begin
            errors++;
            $display("FAIL drain_status: got %0d pending %0d overflows, required 0 and 0", left, ovf_cnt[1]);
        end
    endtask

    task automatic test_overflow;
        int left;
        rdy[1]     = 1'b0;
        ovf_cnt[1] = 0;
        for (int f = 0; f < 5; f++) begin
            if (f < 4) push_exp(1, 64 + f, 3'b000);
            frame8(1, 64 + f, 1'b0);
        end
        repeat (3) @(posedge tx_clk);
        #1;
        checks++;
        if (o_cnt[1] !== 5'd4) begin
            errors++;
            $display("FAIL full_count: got %0d, required 4", o_cnt[1]);
        end
        checks++;
        if (ovf_cnt[1] !== 1) begin
            errors++;
            $display("FAIL overflow_pulse: got %0d cycles, required 1", ovf_cnt[1]);
        end
        rdy[1] = 1'b1;
        wait_drain(left);
        checks++;
        if (left !== 0 || o_cnt[1] !== 5'd0) begin
            errors++;
            $display("FAIL drain_overflow: got %0d pending count %0d, required 0 and 0", left, o_cnt[1]);
        end
    endtask

    task automatic test_full_pop_push;
        int left;
        rdy[1]     = 1'b0;
        ovf_cnt[1] = 0;
        for (int f = 0; f < 4; f++) begin
            push_exp(1, 70 + f, 3'b000);
            frame8(1, 70 + f, 1'b0);
        end
        push_exp(1, 74, 3'b000);
        for (int j = 0; j < 73; j++) beat(1, 4'h1, 1'b0, 1'b0);
        rdy[1] = 1'b1;
        beat(1, 4'h1, 1'b1, 1'b0);
        rdy[1] = 1'b0;
        checks++;
        if (o_cnt[1] !== 5'd4) begin
            errors++;
            $display("FAIL pop_push_count: got %0d, required 4", o_cnt[1]);
        end
        repeat (2) @(posedge tx_clk);
        #1;
        checks++;
        if (ovf_cnt[1] !== 0) begin
            errors++;
            $display("FAIL pop_push_overflow: got %0d pulses, required 0", ovf_cnt[1]);
        end
        rdy[1] = 1'b1;
        wait_drain(left);
        checks++;
        if (left !== 0) begin
            errors++;
            $display("FAIL drain_pop_push: got %0d pending, required 0", left);
        end
    endtask

    task automatic test_saturate_reset;
        int left;
        push_exp(2, 255, 3'b000);
        frame8(2, 300, 1'b0);
        for (int j = 0; j < 100; j++) beat(2, 4'h1, 1'b0, 1'b0);
        checks++;
        if (o_act[2] !== 1'b1) begin
            errors++;
            $display("FAIL active_before_reset: got %b, required 1", o_act[2]);
        end
        tx_rst = 1'b1;
        #1;
        checks++;
        if (o_act[2] !== 1'b0 || o_vld[2] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got act %b vld %b, required 0 0", o_act[2], o_vld[2]);
        end
        @(posedge tx_clk);
        #1;
        tx_rst = 1'b0;
        push_exp(2, 70, 3'b000);
        frame8(2, 70, 1'b0);
        wait_drain(left);
        checks++;
        if (left !== 0) begin
            errors++;
            $display("FAIL drain_saturate: got %0d pending, required 0", left);
        end
    endtask

    task automatic test_drop_bad;
        int left;
        ovf_cnt[3] = 0;
        push_exp(3, 64, 3'b000);
        frame8(3, 64, 1'b0);
        push_exp(3, 100, 3'b000);
        frame8(3, 100, 1'b0);
        frame8(3, 62, 1'b1);
        wait_drain(left);
        repeat (3) @(posedge tx_clk);
        #1;
        checks++;
        if (left !== 0 || o_cnt[3] !== 5'd0 || ovf_cnt[3] !== 0) begin
            errors++;
            $display("FAIL drop_bad: got pending %0d count %0d ovf %0d, required 0 0 0", left, o_cnt[3], ovf_cnt[3]);
        end
`ifdef ETH_TX_LEN_MON_COUNTERS_EN
        checks++;
        if (fc[3] !== 32'd3 || bc[3] !== 32'd226 || dc[3] !== 32'd1) begin
            errors++;
            $display("FAIL counters: got frames %0d bytes %0d drops %0d, required 3 226 1", fc[3], bc[3], dc[3]);
        end
`endif
    endtask

    initial begin
        tx_rst   = 1'b1;
        s_valid  = '0;
        s_ready  = 1'b1;
        s_keep32 = '0;
        s_keep8  = 1'b0;
        s_last   = 1'b0;
        s_user   = 1'b0;
        rdy      = 4'hF;
        for (int i = 0; i < 4; i++) ovf_cnt[i] = 0;
        test_reset;
        test_runt_wide;
        test_oversize_bad;
        test_overflow;
        test_full_pop_push;
        test_saturate_reset;
        test_drop_bad;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_tx_frame_length_monitor.md
Name: eth_tx_frame_length_monitor

Overview:
- Passive monitor on the 1G/multi-byte TX AXI-Stream path in the tx_clk domain, between the TX FIFO output and the MAC.
- Counts bytes per frame using tkeep and classifies each frame as runt, oversize or bad.
- Pushes one length/status descriptor per frame into an internal synchronous descriptor FIFO with a ready/valid output.
- Generalises single-byte RX length capture to arbitrary data width, configurable limits, descriptor depth, overflow handling and status flags.

Parameters:
- DATA_WIDTH, 8: monitored stream width in bits; multiple of 8.
- KEEP_WIDTH, DATA_WIDTH/8: tkeep width.
- LENGTH_WIDTH, 16: descriptor length field width; the accumulator saturates at 2^LENGTH_WIDTH-1.
- MIN_LENGTH, 64: frames shorter than this are flagged runt.
- MAX_LENGTH, 1522: frames longer than this are flagged oversize.
- DEPTH, 16: descriptor FIFO entries; power of two, at least 2.
- DROP_BAD, 0: 1 means frames with tuser=1 on the last beat are not pushed.

Ports:
- tx_clk  in  1  clock
- tx_rst  in  1  reset, asynchronous, active-high
- mon_tkeep  in  KEEP_WIDTH  byte enables of the observed beat; ignored when KEEP_WIDTH==1
- mon_tvalid  in  1  observed valid
- mon_tready  in  1  observed ready; the block never drives it
- mon_tlast  in  1  observed last
- mon_tuser  in  1  observed bad-frame flag
- len_tdata  out  LENGTH_WIDTH  frame length in bytes
- len_tstatus  out  3  {bad, oversize, runt}
- len_tvalid  out  1  descriptor valid
- len_tready  in  1  descriptor accept
- len_count  out  $clog2(DEPTH)+1  FIFO occupancy
- frame_active  out  1  high while the state machine is in ACTIVE
- overflow  out  1  single-cycle pulse when a descriptor is dropped because the FIFO is full

Behaviour:
- Beat accepted = mon_tvalid && mon_tready. Nothing happens on cycles without an accepted beat.
- Beat byte count n:
  - KEEP_WIDTH==1: n = 1.
  - Otherwise: n = popcount(mon_tkeep). A tkeep of 0 contributes 0 bytes.
- State machine:
  - IDLE: entered on reset. Accumulator acc = 0.
  - IDLE -> ACTIVE on an accepted non-last beat.
  - ACTIVE -> IDLE on an accepted last beat.
  - IDLE -> IDLE on a single-beat frame.
- Accumulation:
  - Non-last beat: acc <= sat(acc+n).
  - Last beat: final = sat(acc+n), then acc <= 0.
  - sat() clamps to 2^LENGTH_WIDTH-1 and never wraps.
- Status of the completed frame:
  - runt = final < MIN_LENGTH.
  - oversize = final > MAX_LENGTH, compared at full width.
  - bad = mon_tuser on the last beat.
- Push:
  - Push request = last beat accepted && !(DROP_BAD && bad).
  - Push is accepted if len_count < DEPTH, or if a pop happens in the same cycle (len_tvalid && len_tready).
  - Otherwise the descriptor is discarded and overflow pulses high for exactly 1 cycle. The accumulator is still cleared.
- Latency: a descriptor is visible on len_tdata/len_tstatus with len_tvalid=1 on the cycle after its last beat is accepted, provided the FIFO was empty.
- Output is first-word fall-through; the head entry holds stable while len_tvalid && !len_tready.
- Pop on len_tvalid && len_tready. len_count is updated the next cycle; a simultaneous push and pop leaves it unchanged.
- Ordering: strictly the frame completion order.
- Reset values:
  - len_tvalid=0, len_tdata=0, len_tstatus=0, len_count=0, frame_active=0, overflow=0.
  - acc=0, state IDLE, FIFO pointers 0.
- Reset mid-frame: the partial frame is abandoned. The beats after reset up to the next tlast form a new frame counted from 0.

Optional Feature:
- Macro ETH_TX_LEN_MON_COUNTERS_EN.
- When defined, three 32-bit wrapping output ports are added:
  - frame_count: +1 per accepted last beat.
  - byte_count: +n per accepted beat, unsaturated.
  - drop_count: +1 per overflow or DROP_BAD discard.
  - All are reset to 0 by tx_rst.
- When undefined, these ports and registers do not exist and all other behaviour is identical.

Test Plan:
- DATA_WIDTH=32: 15 beats with tkeep=4'hF, then a last beat with tkeep=4'h3 -> next cycle len_tvalid=1, len_tdata=62, len_tstatus=3'b001.
- DATA_WIDTH=8: 1523-byte frame with tuser=0 -> len_tdata=1523, status=3'b010. Then a 64-byte frame with tuser=1 on the last beat and DROP_BAD=0 -> len_tdata=64, status=3'b100.
- DEPTH=4, len_tready=0, five 64-byte frames -> len_count=4 and overflow pulses once on the fifth tlast. Then release len_tready -> descriptors 1 to 4 appear in order, all 64/3'b000.
- FIFO full with a pop and a push in the same cycle -> no overflow, len_count stays 4, and the new descriptor appears last.
- LENGTH_WIDTH=8, 300-byte frame -> len_tdata=255, status=3'b000 (255 ≤ 1522, ≥ 64). Assert tx_rst after 100 bytes of the next frame, then send a 70-byte frame -> len_tdata=70.
- With ETH_TX_LEN_MON_COUNTERS_EN, three frames of 64, 100 and 62(bad, DROP_BAD=1) bytes -> frame_count=3, byte_count=226, drop_count=1.
